pulse_train_gen: RTL and testbench

PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

---
 rtl/pulse_train_gen_pkg.sv | 14 +
 rtl/pulse_train_gen_phase_timer.sv | 27 ++
 rtl/pulse_train_gen.sv | 106 ++++++++++
 tb/tb_pulse_train_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pulse_train_gen_pkg.sv
// Shared FSM encodings and data-path constants for pulse_train_gen.
package pulse_train_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    FIN  = 2'd3
  } state_t;

  // A requested half period of zero is stretched to this many cycles.
  localparam int MIN_HALF_PERIOD = 1;

endpackage

// File: rtl/pulse_train_gen_phase_timer.sv
// Loadable down-counter with a zero flag; times each HIGH/LOW phase.
module phase_timer #(
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PERIOD_W-1:0] load_val,
  output logic                zero
);

  logic [PERIOD_W-1:0] count;

  // Saturates at zero instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - PERIOD_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Burst pulse-train generator: N pulses, each H cycles high then H cycles low.
// Optional abort input enabled by defining PULSE_TRAIN_GEN_ABORT_EN.
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    pulse_count,
  input  logic [PERIOD_W-1:0] half_period,
`ifdef PULSE_TRAIN_GEN_ABORT_EN
  input  logic                abort,
`endif
  output logic                data_out,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    pulses_sent
);

  state_t              state;
  logic [PERIOD_W-1:0] half_reg;
  logic [PERIOD_W-1:0] half_in;
  logic [PERIOD_W-1:0] timer_val;
  logic [WIDTH-1:0]    pulses_left;
  logic                timer_load;
  logic                phase_end;

  assign half_in = (half_period == '0) ? PERIOD_W'(MIN_HALF_PERIOD) : half_period;

  // The timer reloads on the edge that enters each phase; loads in FIN are harmless.
  assign timer_load = (state == IDLE) ? start : phase_end;
  assign timer_val  = (state == IDLE) ? (half_in - PERIOD_W'(1)) : (half_reg - PERIOD_W'(1));

  phase_timer #(.PERIOD_W(PERIOD_W)) u_phase_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (phase_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      data_out    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulses_sent <= '0;
      pulses_left <= '0;
      half_reg    <= '0;
    end else begin
      done <= 1'b0;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
      if (abort && (state == HIGH || state == LOW)) begin
        state    <= FIN;
        data_out <= 1'b0;
        busy     <= 1'b0;
        done     <= 1'b1;
      end else
`endif
      case (state)
        IDLE: begin
          if (start) begin
            pulses_sent <= '0;
            half_reg    <= half_in;
            pulses_left <= pulse_count;
            if (pulse_count == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state    <= HIGH;
              data_out <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end
        HIGH: begin
          if (phase_end) begin
            state       <= LOW;
            data_out    <= 1'b0;
            pulses_sent <= pulses_sent + WIDTH'(1);
            if (pulses_left != '0) pulses_left <= pulses_left - WIDTH'(1);
          end
        end
        LOW: begin
          if (phase_end) begin
            if (pulses_left == '0) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= HIGH;
              data_out <= 1'b1;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: directed table, hand sequences and random bursts vs a cycle model.
module tb_pulse_train_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pulse_count = '0;
  logic [7:0] half_period = '0;
  logic       abort = 1'b0;
  logic       data_out;
  logic       busy;
  logic       done;
  logic [7:0] pulses_sent;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_cycle = 0;
  logic wave [0:63];

  typedef struct {
    int n;
    int h;
    int abort_at;
    int repulse_at;
    int exp_done;
    int exp_pulses;
  } vec_t;

  vec_t vecs[$];

  pulse_train_gen #(.WIDTH(8), .PERIOD_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pulse_count (pulse_count),
    .half_period (half_period),
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    .abort       (abort),
`endif
    .data_out    (data_out),
    .busy        (busy),
    .done        (done),
    .pulses_sent (pulses_sent)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cur_cycle, act, exp);
    end
  endtask

  // Runs one burst starting now (cycle 0) and compares every cycle against the model.
  task automatic run_burst(input int n, input int h, input int a, input int r,
                           output int done_cyc, output int last_ps);
    int he, end_c, e_data, e_busy, e_done, e_ps, ps_hold;
    he = (h == 0) ? 1 : h;
    end_c = (a != 0) ? a + 1 : ((n == 0) ? 1 : 2 * he * n + 1);
    ps_hold = (a != 0) ? (a - 1 + he) / (2 * he) : n;
    done_cyc = -1;
    last_ps = -1;
    start = 1'b1;
    pulse_count = 8'(n);
    half_period = 8'(h);
    tick();
    start = 1'b0;
    for (int c = 1; c <= end_c + 2; c++) begin
      cur_cycle = c;
      if (c < end_c) begin
        e_data = (((c - 1) / he) % 2 == 0) ? 1 : 0;
        e_busy = 1;
        e_done = 0;
        e_ps   = (c - 1 + he) / (2 * he);
      end else begin
        e_data = 0;
        e_busy = 0;
        e_done = (c == end_c) ? 1 : 0;
        e_ps   = ps_hold;
      end
      chk("data_out", int'(data_out), e_data);
      chk("busy", int'(busy), e_busy);
      chk("done", int'(done), e_done);
      chk("pulses_sent", int'(pulses_sent), e_ps);
      if (done && done_cyc < 0) done_cyc = c;
      if (c < 64) wave[c] = data_out;
      last_ps = int'(pulses_sent);
      pulse_count = 8'($urandom);
      half_period = 8'($urandom);
      start = (c == r);
      abort = (c == a);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int dc, lp, n, h, a, r, he, end_c;
    logic [11:0] pat;

    vecs.push_back('{n: 3,   h: 2,   abort_at: 0, repulse_at: 0, exp_done: 13,  exp_pulses: 3});
    vecs.push_back('{n: 2,   h: 0,   abort_at: 0, repulse_at: 0, exp_done: 5,   exp_pulses: 2});
    vecs.push_back('{n: 0,   h: 4,   abort_at: 0, repulse_at: 0, exp_done: 1,   exp_pulses: 0});
    vecs.push_back('{n: 4,   h: 3,   abort_at: 0, repulse_at: 3, exp_done: 25,  exp_pulses: 4});
    vecs.push_back('{n: 1,   h: 1,   abort_at: 0, repulse_at: 0, exp_done: 3,   exp_pulses: 1});
    vecs.push_back('{n: 1,   h: 255, abort_at: 0, repulse_at: 0, exp_done: 511, exp_pulses: 1});
    vecs.push_back('{n: 255, h: 1,   abort_at: 0, repulse_at: 0, exp_done: 511, exp_pulses: 255});
    vecs.push_back('{n: 3,   h: 1,   abort_at: 0, repulse_at: 5, exp_done: 7,   exp_pulses: 3});
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    vecs.push_back('{n: 5,   h: 2,   abort_at: 6, repulse_at: 0, exp_done: 7,   exp_pulses: 1});
    vecs.push_back('{n: 2,   h: 3,   abort_at: 1, repulse_at: 0, exp_done: 2,   exp_pulses: 0});
`endif

    // Reset state, checked while rst is still held.
    tick();
    tick();
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pulses_sent", int'(pulses_sent), 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_burst(vecs[i].n, vecs[i].h, vecs[i].abort_at, vecs[i].repulse_at, dc, lp);
      cur_cycle = i;
      chk("vec_done_cycle", dc, vecs[i].exp_done);
      chk("vec_final_pulses", lp, vecs[i].exp_pulses);
      if (i == 0) begin
        pat = '0;
        for (int k = 1; k <= 12; k++) pat = {pat[10:0], wave[k]};
        chk("wave_n3_h2", int'(pat), int'(12'b110011001100));
      end
      if (i == 1) begin
        pat = '0;
        for (int k = 1; k <= 4; k++) pat = {pat[10:0], wave[k]};
        chk("wave_n2_h0", int'(pat), int'(12'b000000001010));
      end
      repeat (2) tick();
    end

    // Reset in the middle of an N=4, H=2 burst.
    start = 1'b1;
    pulse_count = 8'd4;
    half_period = 8'd2;
    tick();
    start = 1'b0;
    repeat (4) tick();
    cur_cycle = 5;
    chk("pre_rst_busy", int'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_data_out", int'(data_out), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    chk("async_rst_pulses_sent", int'(pulses_sent), 0);
    tick();
    chk("held_rst_done", int'(done), 0);
    chk("held_rst_busy", int'(busy), 0);
    rst = 1'b0;
    run_burst(4, 2, 0, 0, dc, lp);
    cur_cycle = 0;
    chk("post_rst_done_cycle", dc, 17);
    chk("post_rst_pulses", lp, 4);

    // Random bursts against the model.
    for (int i = 0; i < 25; i++) begin
      n = $urandom_range(0, 6);
      h = $urandom_range(0, 4);
      he = (h == 0) ? 1 : h;
      a = 0;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
      if (n > 0 && $urandom_range(0, 1) == 1) a = $urandom_range(1, 2 * he * n);
`endif
      end_c = (a != 0) ? a + 1 : ((n == 0) ? 1 : 2 * he * n + 1);
      r = (end_c > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, end_c - 1) : 0;
      run_burst(n, h, a, r, dc, lp);
      cur_cycle = i;
      chk("rand_done_cycle", dc, end_c);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
